core_run_ctrl: RTL and testbench

//  Parametrised run controller for the RISC-V core top. Sequences core reset, runs the program and

---
 rtl/core_run_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_core_run_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : core_run_ctrl                                                 |
// | Description : Run controller for the RISC-V core. Holds the core in reset   |
// |               for RST_CYCLES, runs the program, and counts RUN cycles and   |
// |               writebacks. A run ends on a halt instruction, a PC self-loop  |
// |               or the cycle budget, and the cause is reported.               |
// |               Optional macro RUN_CTRL_SIGNATURE_EN adds a rotate-xor        |
// |               writeback signature; without it signature_o is tied to 0.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module core_run_ctrl #(
  parameter int          XLEN        = 32,
  parameter int          CNT_W       = 32,
  parameter int          RST_CYCLES  = 4,
  parameter int          MAX_CYCLES  = 1000,
  parameter int          STALL_LIMIT = 8,
  parameter logic [31:0] HALT_INSTR  = 32'h0010_0073
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      instr_i,
  input  logic             reg_write_i,
  input  logic [XLEN-1:0]  result_i,
  output logic             core_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       cause_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] wb_cnt_o,
  output logic [XLEN-1:0]  signature_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESET = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] c_CAUSE_NONE  = 2'b00;
  localparam logic [1:0] c_CAUSE_HALT  = 2'b01;
  localparam logic [1:0] c_CAUSE_STALL = 2'b10;
  localparam logic [1:0] c_CAUSE_TMO   = 2'b11;

  localparam logic [CNT_W-1:0] c_RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_MAX_CYC   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] c_STALL_LIM = CNT_W'(STALL_LIMIT);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_rst_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_wb_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [XLEN-1:0]  r_prev_pc;
  logic [1:0]       r_cause;
  logic             r_core_rst;
  logic             r_busy;
  logic             r_done;

  logic             w_run_start;
  logic             w_first_run;
  logic [CNT_W-1:0] w_cyc_inc;
  logic [CNT_W-1:0] w_wb_inc;
  logic [CNT_W-1:0] w_stall_nxt;
  logic             w_term;
  logic [1:0]       w_cause_nxt;
  logic             w_core_rst_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // A new run begins from IDLE or DONE; abort always wins over start.
  assign w_run_start = start_i && !abort_i && (r_state == S_IDLE || r_state == S_DONE);

  // RUN-cycle arithmetic: saturating counters, stall tracking and termination cause.
  always_comb begin
    // cycle_cnt is zero only before the first RUN cycle, so it doubles as "no previous PC".
    w_first_run = (r_cycle_cnt == '0);
    w_cyc_inc   = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + 1'b1;
    w_wb_inc    = (reg_write_i && !(&r_wb_cnt)) ? r_wb_cnt + 1'b1 : r_wb_cnt;
    w_stall_nxt = '0;
    if (!w_first_run && pc_i == r_prev_pc)
      w_stall_nxt = (&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + 1'b1;
    w_cause_nxt = c_CAUSE_NONE;
    if (instr_i == HALT_INSTR)
      w_cause_nxt = c_CAUSE_HALT;
    else if (w_stall_nxt >= c_STALL_LIM)
      w_cause_nxt = c_CAUSE_STALL;
    else if (w_cyc_inc >= c_MAX_CYC)
      w_cause_nxt = c_CAUSE_TMO;
    w_term = (w_cause_nxt != c_CAUSE_NONE);
  end

  // Next-state logic for IDLE -> RESET -> RUN -> DONE with abort back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_run_start) w_state_nxt = S_RESET;
      S_RESET: begin
        if (abort_i)                      w_state_nxt = S_IDLE;
        else if (r_rst_cnt == c_RST_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (abort_i)     w_state_nxt = S_IDLE;
        else if (w_term) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (abort_i)          w_state_nxt = S_IDLE;
        else if (w_run_start) w_state_nxt = S_RESET;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so the flopped outputs track the state register.
  always_comb begin
    w_core_rst_nxt = (w_state_nxt == S_RUN);
    w_busy_nxt     = (w_state_nxt == S_RESET) || (w_state_nxt == S_RUN);
    w_done_nxt     = (w_state_nxt == S_DONE);
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_core_rst <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_core_rst <= w_core_rst_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Run counters, stall tracking and cause; cleared on run start, held outside RESET/RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_cnt   <= '0;
      r_cycle_cnt <= '0;
      r_wb_cnt    <= '0;
      r_stall_cnt <= '0;
      r_prev_pc   <= '0;
      r_cause     <= c_CAUSE_NONE;
    end else if (w_run_start) begin
      r_rst_cnt   <= '0;
      r_cycle_cnt <= '0;
      r_wb_cnt    <= '0;
      r_stall_cnt <= '0;
      r_prev_pc   <= '0;
      r_cause     <= c_CAUSE_NONE;
    end else if (r_state == S_RESET) begin
      r_rst_cnt <= r_rst_cnt + 1'b1;
    end else if (r_state == S_RUN) begin
      // The aborting cycle is still a sampled RUN cycle and is counted.
      r_cycle_cnt <= w_cyc_inc;
      r_wb_cnt    <= w_wb_inc;
      r_stall_cnt <= w_stall_nxt;
      r_prev_pc   <= pc_i;
      if (!abort_i && w_term)
        r_cause <= w_cause_nxt;
    end
  end

`ifdef RUN_CTRL_SIGNATURE_EN
  logic [XLEN-1:0] r_signature;

  // Rotate-left-by-one then xor each writeback value into the signature.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_signature <= '0;
    else if (w_run_start)
      r_signature <= '0;
    else if (r_state == S_RUN && reg_write_i)
      r_signature <= {r_signature[XLEN-2:0], r_signature[XLEN-1]} ^ result_i;
  end

  assign signature_o = r_signature;
`else
  logic w_sig_unused;
  assign w_sig_unused = ^result_i;
  assign signature_o  = '0;
`endif

  assign core_rst_o  = r_core_rst;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign cause_o     = r_cause;
  assign cycle_cnt_o = r_cycle_cnt;
  assign wb_cnt_o    = r_wb_cnt;

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_core_run_ctrl                                              |
// | Description : Self-checking bench for core_run_ctrl with randomized RUN     |
// |               stimulus and a per-run reference model of the run rules.      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_core_run_ctrl;
  localparam int          XLEN        = 32;
  localparam int          CNT_W       = 32;
  localparam int          RST_CYCLES  = 4;
  localparam int          MAX_CYCLES  = 20;
  localparam int          STALL_LIMIT = 8;
  localparam logic [31:0] HALT        = 32'h0010_0073;

  localparam int M_RAND  = 0;
  localparam int M_HALT  = 1;
  localparam int M_STALL = 2;
  localparam int M_MOVE  = 3;
  localparam int M_ABORT = 4;
  localparam int M_SIG   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [XLEN-1:0]  pc_i = '0;
  logic [31:0]      instr_i = '0;
  logic             reg_write_i = 1'b0;
  logic [XLEN-1:0]  result_i = '0;
  logic             core_rst_o;
  logic             busy_o;
  logic             done_o;
  logic [1:0]       cause_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] wb_cnt_o;
  logic [XLEN-1:0]  signature_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the current run
  int          m_cyc;
  int          m_wb;
  int          m_stall;
  logic [31:0] m_prev;
  logic [31:0] m_sig;
  logic [1:0]  m_cause;

  core_run_ctrl #(
    .XLEN(XLEN), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES),
    .STALL_LIMIT(STALL_LIMIT), .HALT_INSTR(HALT)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .pc_i(pc_i),
    .instr_i(instr_i), .reg_write_i(reg_write_i), .result_i(result_i),
    .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o), .cause_o(cause_o),
    .cycle_cnt_o(cycle_cnt_o), .wb_cnt_o(wb_cnt_o), .signature_o(signature_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({core_rst_o, busy_o, done_o, cause_o} !== 5'b0 || cycle_cnt_o !== '0 ||
        wb_cnt_o !== '0 || signature_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: core_rst=%b busy=%b done=%b cause=%b cyc=%0d wb=%0d sig=%h, required all zero",
               core_rst_o, busy_o, done_o, cause_o, cycle_cnt_o, wb_cnt_o, signature_o);
    end
    tick;
    tick;
    rst = 1'b1;
    tick;
    n_checks++;
    if ({core_rst_o, busy_o, done_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: core_rst/busy/done=%b, required 000", {core_rst_o, busy_o, done_o});
    end
  endtask

  // Pulse start and walk the RESET phase, then clear the model.
  task automatic start_run;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    n_checks++;
    if ({core_rst_o, busy_o, done_o, cause_o} !== 5'b01000 || cycle_cnt_o !== '0 ||
        wb_cnt_o !== '0 || signature_o !== '0) begin
      n_fail++;
      $display("FAIL start_clear: core_rst=%b busy=%b done=%b cause=%b cyc=%0d wb=%0d sig=%h, required 0 1 0 00 0 0 0",
               core_rst_o, busy_o, done_o, cause_o, cycle_cnt_o, wb_cnt_o, signature_o);
    end
    for (int k = 1; k < RST_CYCLES; k++) begin
      tick;
      n_checks++;
      if (core_rst_o !== 1'b0 || busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold edge %0d: core_rst=%b busy=%b, required 0 1", k, core_rst_o, busy_o);
      end
    end
    tick;
    n_checks++;
    if (core_rst_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: core_rst=%b busy=%b, required 1 1", core_rst_o, busy_o);
    end
    m_cyc = 0; m_wb = 0; m_stall = 0; m_prev = '0; m_sig = '0; m_cause = 2'b00;
  endtask

  // Drive RUN cycles per mode and compare each cycle against the model.
  task automatic run_case(input int mode, input int arg);
    logic [31:0] pc, instr, res;
    logic        rw;
    logic [4:0]  exp_st;
    for (int n = 1; n <= 200; n++) begin
      rw    = 1'($urandom_range(0, 1));
      res   = $urandom;
      instr = $urandom;
      if (instr == HALT) instr = 32'h0;
      pc    = 32'h100 + 32'(4 * n);
      start_i = (mode == M_ABORT) ? 1'b0 : 1'($urandom_range(0, 1));
      case (mode)
        M_RAND: begin
          if (n > 1 && $urandom_range(0, 2) == 0) pc = m_prev;
          if ($urandom_range(0, 29) == 0) instr = HALT;
        end
        M_HALT:  if (n == arg) instr = HALT;
        M_STALL: pc = 32'h40;
        M_ABORT: if (n == arg) begin abort_i = 1'b1; start_i = 1'b1; end
        M_SIG: begin
          rw  = (n <= 2);
          res = (n == 1) ? 32'h1 : 32'h4;
          if (n == 3) instr = HALT;
        end
        default: ;
      endcase
      pc_i = pc; instr_i = instr; reg_write_i = rw; result_i = res;
      tick;
      m_cyc++;
      if (rw) m_wb++;
      m_stall = (n > 1 && pc == m_prev) ? m_stall + 1 : 0;
      m_prev  = pc;
`ifdef RUN_CTRL_SIGNATURE_EN
      if (rw) m_sig = {m_sig[30:0], m_sig[31]} ^ res;
`endif
      if (mode == M_ABORT && n == arg) begin
        abort_i = 1'b0;
        start_i = 1'b0;
        n_checks++;
        if ({core_rst_o, busy_o, done_o, cause_o} !== 5'b00000 || cycle_cnt_o !== CNT_W'(m_cyc)) begin
          n_fail++;
          $display("FAIL abort: core_rst=%b busy=%b done=%b cause=%b cyc=%0d, required 0 0 0 00 %0d",
                   core_rst_o, busy_o, done_o, cause_o, cycle_cnt_o, m_cyc);
        end
        return;
      end
      if (instr == HALT)              m_cause = 2'b01;
      else if (m_stall >= STALL_LIMIT) m_cause = 2'b10;
      else if (m_cyc >= MAX_CYCLES)    m_cause = 2'b11;
      exp_st = (m_cause != 2'b00) ? {3'b001, m_cause} : 5'b11000;
      n_checks++;
      if ({core_rst_o, busy_o, done_o, cause_o} !== exp_st || cycle_cnt_o !== CNT_W'(m_cyc) ||
          wb_cnt_o !== CNT_W'(m_wb) || signature_o !== m_sig) begin
        n_fail++;
        $display("FAIL run_cycle %0d mode %0d: status=%b cyc=%0d wb=%0d sig=%h, required status=%b cyc=%0d wb=%0d sig=%h",
                 n, mode, {core_rst_o, busy_o, done_o, cause_o}, cycle_cnt_o, wb_cnt_o, signature_o,
                 exp_st, m_cyc, m_wb, m_sig);
      end
      if (m_cause != 2'b00) begin
        start_i = 1'b0;
        return;
      end
    end
    start_i = 1'b0;
    n_checks++;
    n_fail++;
    $display("FAIL run_bound mode %0d: no termination in 200 cycles, required termination", mode);
  endtask

  // DONE must freeze everything while inputs keep changing.
  task automatic check_done_hold;
    for (int k = 0; k < 3; k++) begin
      pc_i = $urandom; instr_i = HALT; reg_write_i = 1'b1; result_i = $urandom;
      tick;
      n_checks++;
      if ({core_rst_o, busy_o, done_o, cause_o} !== {3'b001, m_cause} || cycle_cnt_o !== CNT_W'(m_cyc) ||
          wb_cnt_o !== CNT_W'(m_wb) || signature_o !== m_sig) begin
        n_fail++;
        $display("FAIL done_hold: status=%b cyc=%0d wb=%0d sig=%h, required status=%b cyc=%0d wb=%0d sig=%h",
                 {core_rst_o, busy_o, done_o, cause_o}, cycle_cnt_o, wb_cnt_o, signature_o,
                 {3'b001, m_cause}, m_cyc, m_wb, m_sig);
      end
    end
  endtask

  task automatic test_halt;
    start_run;
    run_case(M_HALT, 10);
    n_checks++;
    if (cause_o !== 2'b01 || cycle_cnt_o !== 32'd10 || done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_10: cause=%b cyc=%0d done=%b, required 01 10 1", cause_o, cycle_cnt_o, done_o);
    end
    check_done_hold;
  endtask

  task automatic test_stall;
    start_run;
    run_case(M_STALL, 0);
    n_checks++;
    if (cause_o !== 2'b10 || cycle_cnt_o !== 32'd9) begin
      n_fail++;
      $display("FAIL stall: cause=%b cyc=%0d, required 10 9", cause_o, cycle_cnt_o);
    end
  endtask

  task automatic test_timeout;
    start_run;
    run_case(M_MOVE, 0);
    n_checks++;
    if (cause_o !== 2'b11 || cycle_cnt_o !== 32'd20) begin
      n_fail++;
      $display("FAIL timeout: cause=%b cyc=%0d, required 11 20", cause_o, cycle_cnt_o);
    end
    start_run;
    run_case(M_HALT, 20);
    n_checks++;
    if (cause_o !== 2'b01 || cycle_cnt_o !== 32'd20) begin
      n_fail++;
      $display("FAIL halt_at_budget: cause=%b cyc=%0d, required 01 20", cause_o, cycle_cnt_o);
    end
  endtask

  task automatic test_abort;
    start_run;
    run_case(M_ABORT, 5);
    n_checks++;
    if (cycle_cnt_o !== 32'd5 || done_o !== 1'b0 || core_rst_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_run5: cyc=%0d done=%b core_rst=%b, required 5 0 0", cycle_cnt_o, done_o, core_rst_o);
    end
    tick;
    n_checks++;
    if ({busy_o, done_o} !== 2'b00 || cycle_cnt_o !== 32'd5) begin
      n_fail++;
      $display("FAIL abort_idle_hold: busy=%b done=%b cyc=%0d, required 0 0 5", busy_o, done_o, cycle_cnt_o);
    end
    // Abort during the RESET phase
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    abort_i = 1'b1;
    tick;
    abort_i = 1'b0;
    n_checks++;
    if ({core_rst_o, busy_o, done_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_in_reset: core_rst/busy/done=%b, required 000", {core_rst_o, busy_o, done_o});
    end
  endtask

  task automatic test_signature;
    start_run;
    run_case(M_SIG, 0);
    n_checks++;
`ifdef RUN_CTRL_SIGNATURE_EN
    if (signature_o !== 32'h6 || wb_cnt_o !== 32'd2) begin
      n_fail++;
      $display("FAIL signature: sig=%h wb=%0d, required 00000006 2", signature_o, wb_cnt_o);
    end
`else
    if (signature_o !== 32'h0 || wb_cnt_o !== 32'd2) begin
      n_fail++;
      $display("FAIL signature: sig=%h wb=%0d, required 00000000 2", signature_o, wb_cnt_o);
    end
`endif
  endtask

  task automatic test_random;
    for (int r = 0; r < 10; r++) begin
      start_run;
      run_case(M_RAND, 0);
    end
  endtask

  task automatic test_async_reset;
    start_run;
    for (int k = 0; k < 3; k++) begin
      pc_i = 32'(k * 4); instr_i = 32'h0; reg_write_i = 1'b1; result_i = $urandom;
      tick;
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({core_rst_o, busy_o, done_o, cause_o} !== 5'b0 || cycle_cnt_o !== '0 ||
        wb_cnt_o !== '0 || signature_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: core_rst=%b busy=%b done=%b cause=%b cyc=%0d wb=%0d sig=%h, required all zero",
               core_rst_o, busy_o, done_o, cause_o, cycle_cnt_o, wb_cnt_o, signature_o);
    end
    tick;
    rst = 1'b1;
    tick;
    n_checks++;
    if ({core_rst_o, busy_o, done_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset_idle: core_rst/busy/done=%b, required 000", {core_rst_o, busy_o, done_o});
    end
  endtask

  initial begin
    test_reset;
    start_run;
    run_case(M_MOVE, 0);
    test_halt;
    test_stall;
    test_timeout;
    test_abort;
    test_signature;
    test_random;
    test_async_reset;
    start_run;
    run_case(M_HALT, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
